muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that owns the HI/LO registers of the pipelined core. It executes the signed and unsigned MULT/MULTU/DIV/DIVU operations launched by the main decoder's start and sign controls. It serves MFHI/MFLO reads and MTHI/MTLO writes, and it raises a stall request while a result is pending. It sits beside the EX stage; its HI/LO outputs feed the EX-stage output select mux.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 53 +++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM states and constants for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // LO value written by a divide by zero: all ones in the low 'width' bits.
    function automatic logic [63:0] div0_lo(input int width);
        return ~({64{1'b1}} << width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : UNROLL combinational shift-add / restoring-divide iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_opd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;

    always_comb begin
        w_acc = i_acc;
        w_shr = i_shreg;
        w_sum = '0;
        w_rem = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (i_div) begin
                // Remainder stays below the divisor, so the difference fits in WIDTH bits.
                w_rem = {w_acc, w_shr[WIDTH-1]};
                if (w_rem >= {1'b0, i_opd}) begin
                    w_sum = w_rem - {1'b0, i_opd};
                    w_acc = w_sum[WIDTH-1:0];
                    w_shr = {w_shr[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc = w_rem[WIDTH-1:0];
                    w_shr = {w_shr[WIDTH-2:0], 1'b0};
                end
            end else begin
                w_sum = w_shr[0] ? ({1'b0, w_acc} + {1'b0, i_opd}) : {1'b0, w_acc};
                w_shr = {w_sum[0], w_shr[WIDTH-1:1]};
                w_acc = w_sum[WIDTH:1];
            end
        end
    end

    assign o_acc   = w_acc;
    assign o_shreg = w_shr;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_req,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int               N      = WIDTH / UNROLL;
    localparam int               CW     = $clog2(N + 1);
    localparam logic [WIDTH-1:0] C_DIV0 = WIDTH'(div0_lo(WIDTH));

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_shreg, r_opd, r_hi, r_lo;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0, r_done;

    logic             w_signed, w_sa, w_sb, w_launch;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_acc_nxt, w_shreg_nxt;
    logic [WIDTH-1:0] w_quo, w_rem, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_sa ? -a : a;
    assign w_mag_b  = w_sb ? -b : b;
    assign w_launch = (r_state == S_IDLE) && start && !flush;

    muldiv_step #(
        .WIDTH  (WIDTH),
        .UNROLL (UNROLL)
    ) u_step (
        .i_div   (r_is_div),
        .i_acc   (r_acc),
        .i_shreg (r_shreg),
        .i_opd   (r_opd),
        .o_acc   (w_acc_nxt),
        .o_shreg (w_shreg_nxt)
    );

    // Sign correction applied on the magnitude result in FIX.
    assign w_prod   = r_neg_q ? -{r_acc, r_shreg} : {r_acc, r_shreg};
    assign w_quo    = r_div0 ? C_DIV0 : (r_neg_q ? -r_shreg : r_shreg);
    assign w_rem    = r_neg_r ? -r_acc : r_acc;
    assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_CALC;
            S_CALC:  begin
                if (flush)                w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_shreg  <= '0;
            r_opd    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (w_launch) begin
                        r_acc    <= '0;
                        r_shreg  <= w_mag_a;
                        r_opd    <= w_mag_b;
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= op[1] && (b == '0);
                        r_cnt    <= CW'(N);
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_cnt <= '0;
                    end else begin
                        r_acc   <= w_acc_nxt;
                        r_shreg <= w_shreg_nxt;
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign stall = busy && (rd_req || start || mthi || mtlo);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (UNROLL 1/2/4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, flush = 1'b0, rd_req = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;

    logic [31:0] hi1, lo1, hi2, lo2, hi4, lo4;
    logic        busy1, done1, stall1, busy2, done2, stall2, busy4, done4, stall4;

    int checks = 0;
    int failures = 0;
    int lat1, lat2, lat4, busy_cnt, dcnt;
    logic [31:0] rh1, rl1, rh2, rl2, rh4, rl4;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .rd_req(rd_req), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi1), .lo(lo1), .busy(busy1), .done(done1), .stall(stall1));

    muldiv_unit #(.WIDTH(32), .UNROLL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .rd_req(rd_req), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi2), .lo(lo2), .busy(busy2), .done(done2), .stall(stall2));

    muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .rd_req(rd_req), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi4), .lo(lo4), .busy(busy4), .done(done4), .stall(stall4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        if (o[1] && y == 32'h0) return {x, 32'hFFFF_FFFF};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            2'b10: begin
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            default: return {32'(ux % uy), 32'(ux / uy)};
        endcase
    endfunction

    // Launches one operation on all three units and checks latency and HI/LO.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy1 ? 1 : 0;
        lat1 = 0; lat2 = 0; lat4 = 0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (busy1) busy_cnt++;
            if (done1 && lat1 == 0) begin lat1 = k; rh1 = hi1; rl1 = lo1; end
            if (done2 && lat2 == 0) begin lat2 = k; rh2 = hi2; rl2 = lo2; end
            if (done4 && lat4 == 0) begin lat4 = k; rh4 = hi4; rl4 = lo4; end
        end
        chk({tag, "_lat_u1"}, 64'(lat1), 64'd34);
        chk({tag, "_lat_u2"}, 64'(lat2), 64'd18);
        chk({tag, "_lat_u4"}, 64'(lat4), 64'd10);
        chk({tag, "_busy_u1"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_hilo_u1"}, {rh1, rl1}, {eh, el});
        chk({tag, "_hilo_u2"}, {rh2, rl2}, {eh, el});
        chk({tag, "_hilo_u4"}, {rh4, rl4}, {eh, el});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] ex;

        repeat (3) tick();
        chk("rst_hi", 64'(hi1), 64'h0);
        chk("rst_lo", 64'(lo1), 64'h0);
        chk("rst_flags", {61'h0, busy1, done1, stall1}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("divu_7_2",    2'b11, 32'h7,         32'h2,         32'h1,         32'h3);
        do_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_min_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        do_op("divu_by0",    2'b11, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF);
        do_op("div_m5_by0",  2'b10, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // rd_req held through a DIVU 100/7, with an ignored start mid-operation
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; rd_req = 1'b1;
        #1;
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) tick();
            chk("stall_vs_cycle", 64'(stall1), (k <= 33) ? 64'd1 : 64'd0);
            if (k == 10) begin op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h1; start = 1'b1; end
            if (k == 11) start = 1'b0;
        end
        chk("stall_done", 64'(done1), 64'd1);
        chk("stall_hilo", {hi1, lo1}, {32'd2, 32'd14});
        rd_req = 1'b0;
        repeat (4) tick();

        // MTHI/MTLO together, then a flushed MULTU
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 1'b0; wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mt_hilo", {hi1, lo1}, {32'hAAAA_5555, 32'h0F0F_0F0F});
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy1), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done1) dcnt++;
        end
        chk("flush_nodone", 64'(dcnt), 64'd0);
        chk("flush_hilo", {hi1, lo1}, {32'hAAAA_5555, 32'h0F0F_0F0F});

        // flush arriving in the FIX cycle beats completion
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 33; k++) tick();
        chk("fix_busy", 64'(busy1), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fixflush_flags", {62'h0, busy1, done1}, 64'h0);
        chk("fixflush_hilo", {hi1, lo1}, {32'hAAAA_5555, 32'h0F0F_0F0F});
        repeat (12) tick();

        // flush together with start in IDLE launches nothing
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", 64'(busy1), 64'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 20; k++) tick();
        rd_req = 1'b1;
        #1;
        chk("pre_rst_stall", 64'(stall1), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_hilo", {hi1, lo1}, 64'h0);
        chk("arst_flags", {61'h0, busy1, done1, stall1}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; rd_req = 1'b0;
        do_op("post_rst_mult", 2'b00, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC);

        // random sweep against the reference model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom();
            if (i == 5) rb = 32'hFFFF_FFFF;
            ex = model(ro, ra, rb);
            do_op("sweep", ro, ra, rb, ex[63:32], ex[31:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
